uart_tx_sequencer: RTL

- Transmit-side bit sequencer for the UART core.
- Accepts one parallel character per valid/ready handshake and serialises it onto txd as a frame: start bit, 5–8 data bits (LSB first), optional parity, then 1 or 2 stop bits.
- Each bit lasts OVS baud-enable ticks, timed by an internal load/enable/terminal-count down counter.
- Sits between the TX holding register/FIFO and the pad; brg_tick comes from the baud-rate generator.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tick_counter.sv | 30 +++
 rtl/uart_tx_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit path
// Word-length decode and parity generation used by the TX sequencer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    typedef logic [1:0] wlen_t;

    function automatic logic [3:0] wlen_bits(input wlen_t w);
        return 4'd5 + {2'b00, w};
    endfunction

    function automatic logic [7:0] wlen_mask(input wlen_t w);
        return 8'hFF >> (2'd3 - w);
    endfunction

    // Even parity makes the total count of ones even, so the bit is the plain XOR.
    function automatic logic parity_calc(input logic [7:0] data, input wlen_t w, input logic even);
        logic x;
        x = ^(data & wlen_mask(w));
        return even ? x : ~x;
    endfunction

endpackage

// File: rtl/uart_tick_counter.sv
// rtl/uart_tick_counter.sv - loadable down counter with enable and terminal count
// Terminal count fires on an enabled cycle at zero; that cycle never wraps the count.
module uart_tick_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_tc
);

    logic [W-1:0] r_count;
    logic         w_zero;

    assign w_zero = (r_count == '0);
    assign o_tc   = w_zero & i_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !w_zero) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - UART transmit bit sequencer (start, data, parity, stop)
// Optional line-break control via macro UART_TX_BREAK_EN (adds input brk).
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int OVS = 16,
    parameter int CW  = $clog2(OVS)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       brg_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  wlen_t      wlen,
    input  logic       par_en,
    input  logic       par_even,
    input  logic       stop2,
`ifdef UART_TX_BREAK_EN
    input  logic       brk,
`endif
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam logic [CW-1:0] LP_TICK_LOAD = CW'(OVS - 1);

    tx_state_t   r_state;
    logic        r_txd;
    logic        r_busy;
    logic        r_done;
    logic        r_tx_ready;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_shift;
    wlen_t       r_wlen;
    logic        r_par_en;
    logic        r_par;
    logic        r_stop2;

    logic        w_brk;
    logic        w_xfer;
    logic        w_tick_tc;
    logic        w_bit_end;
    logic        w_load;

`ifdef UART_TX_BREAK_EN
    assign w_brk = brk;
`else
    assign w_brk = 1'b0;
`endif

    assign w_xfer    = tx_valid & r_tx_ready;
    assign w_bit_end = w_tick_tc & (r_state != IDLE);
    // Every bit boundary starts a fresh OVS-tick bit, including the second stop bit.
    assign w_load    = w_xfer | w_bit_end;

    uart_tick_counter #(
        .W (CW)
    ) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (LP_TICK_LOAD),
        .i_en       (brg_tick),
        .o_tc       (w_tick_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_bitcnt   <= 3'd0;
            r_shift    <= 8'd0;
            r_wlen     <= 2'd0;
            r_par_en   <= 1'b0;
            r_par      <= 1'b0;
            r_stop2    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_state    <= START;
                        r_txd      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_tx_ready <= 1'b0;
                        r_shift    <= tx_data & wlen_mask(wlen);
                        r_wlen     <= wlen;
                        r_par_en   <= par_en;
                        r_stop2    <= stop2;
                        r_par      <= parity_calc(tx_data, wlen, par_even);
                    end else begin
                        r_txd      <= ~w_brk;
                        r_tx_ready <= ~w_brk;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state  <= DATA;
                        r_bitcnt <= 3'(wlen_bits(r_wlen) - 4'd1);
                        r_txd    <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bitcnt == 3'd0) begin
                            if (r_par_en) begin
                                r_state <= PARITY;
                                r_txd   <= r_par;
                            end else begin
                                r_state  <= STOP;
                                r_txd    <= 1'b1;
                                r_bitcnt <= {2'b00, r_stop2};
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt - 3'd1;
                            r_txd    <= r_shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        r_state  <= STOP;
                        r_txd    <= 1'b1;
                        r_bitcnt <= {2'b00, r_stop2};
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (r_bitcnt == 3'd0) begin
                            // A pending break takes hold right as the frame completes.
                            r_state    <= IDLE;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_txd      <= ~w_brk;
                            r_tx_ready <= ~w_brk;
                        end else begin
                            r_bitcnt <= r_bitcnt - 3'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_ready = r_tx_ready;
    assign txd      = r_txd;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
